// File: rtl/pipe_pkg.sv
// Shared types and payload layout for the inter-stage pipeline boundary registers.
// Stage wrappers use the offsets and pack helper to build and split payload bundles.
package pipe_pkg;

   // Encoding doubles as the occupancy count (EMPTY=0, FULL=1, SKID=2).
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } skid_state_e;

   localparam int RESULT_W = 32;
   localparam int RD_W     = 5;
   localparam int LEN_W    = 3;
   localparam int RW_W     = 2;

   localparam int RESULT_LSB   = 0;
   localparam int RD_LSB       = RESULT_LSB + RESULT_W;
   localparam int LEN_LSB      = RD_LSB + RD_W;
   localparam int RW_LSB       = LEN_LSB + LEN_W;
   localparam int WB_VALID_BIT = RW_LSB + RW_W;
   localparam int WB_SRC_BIT   = WB_VALID_BIT + 1;

   localparam int EX_MEM1_W   = RESULT_W + RD_W + LEN_W + RW_W + 1 + 1;
   localparam int MEM1_MEM2_W = EX_MEM1_W;
   localparam int MEM2_WB_W   = RESULT_W + RD_W + 1 + 1;

   function automatic logic [EX_MEM1_W-1:0] pack_mem1(
      input logic [RESULT_W-1:0] result,
      input logic [RD_W-1:0]     rd,
      input logic [LEN_W-1:0]    len,
      input logic [RW_W-1:0]     rw,
      input logic                wb_valid,
      input logic                wb_src
   );
      return {wb_src, wb_valid, rw, len, rd, result};
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, stall hold, flush with a
// forwarded one-cycle flush pulse, and an optional 2-entry skid buffer.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH    = EX_MEM1_W,
   parameter bit               SKID_EN  = 1'b1,
   parameter logic [WIDTH-1:0] RST_DATA = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             stall,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             flush_out,
   output logic [1:0]       occupancy
);

   // Handshake: a word moves on a side only in a cycle where its valid and ready are
   // both high; stall masks the downstream side exactly like out_ready=0.
   skid_state_e      state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_ready_q;
   logic             flush_out_q;
   logic             in_xfer;
   logic             out_xfer;

   assign out_valid = (state_q != ST_EMPTY);
   assign out_xfer  = out_valid & out_ready & ~stall;
   assign in_ready  = SKID_EN ? in_ready_q
                              : (~rst & (~out_valid | (out_ready & ~stall)));
   assign in_xfer   = in_valid & in_ready;

   assign out_data  = main_q;
   assign flush_out = flush_out_q;
   assign occupancy = state_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      // Flush empties the stage but leaves data registers untouched (don't-care while invalid).
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state_d = ST_FULL;
                  main_d  = in_data;
               end
            end
            ST_FULL: begin
               if (in_xfer && out_xfer) begin
                  main_d = in_data;
               end else if (in_xfer && SKID_EN) begin
                  state_d = ST_SKID;
                  skid_d  = in_data;
               end else if (out_xfer) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (out_xfer) begin
                  state_d = ST_FULL;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_q      <= RST_DATA;
         skid_q      <= RST_DATA;
         in_ready_q  <= 1'b0;
         flush_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= (state_d != ST_SKID);
         flush_out_q <= flush;
      end
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline segment register for the inter-stage boundaries (EX->MEM1, MEM1->MEM2, ...).
- Replaces hand-written per-stage stall/clear registers with one block: configurable payload width, valid/ready handshake, stall hold, flush with propagated flush pulse, and an optional 2-entry skid mode that registers in_ready to cut the backward ready path.
- One instance per pipeline boundary. The payload is the concatenated stage signals (result, rd index, length, rw, wb valid/src).

Parameters:
- WIDTH, 44, payload width in bits (default = 32+5+3+2+1+1 Memory1 bundle).
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- RST_DATA, 0, value loaded into out_data and the skid entry on reset.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  WIDTH  upstream payload.
- stall  in  1  hold request from hazard unit; blocks output transfer.
- flush  in  1  kill all held entries (branch/exception clear).
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream can accept.
- out_data  out  WIDTH  payload to next stage.
- flush_out  out  1  registered flush, forwarded to the next stage's flush input.
- occupancy  out  2  entries held (0..2; max 1 when SKID_EN=0).

Behaviour:
- Transfers:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready & !stall. stall behaves exactly as out_ready=0.
- Reset (priority over everything):
  - state EMPTY, out_valid=0, flush_out=0, occupancy=0.
  - out_data and skid entry = RST_DATA.
  - in_ready=0 during the reset cycle; in_ready=1 from the first cycle after rst deasserts.
- Flush (priority over stall and handshake):
  - Next cycle: state EMPTY, out_valid=0, occupancy=0, flush_out=1 for exactly one cycle per flush cycle.
  - A payload presented with in_xfer in the flush cycle is dropped.
  - Data registers keep their values; this is don't-care while out_valid=0.
- SKID_EN=0:
  - Single register.
  - in_ready = !out_valid | (out_ready & !stall) (combinational).
  - in_xfer loads out_data and sets out_valid; out_xfer without in_xfer clears out_valid.
  - Latency 1 cycle; throughput 1/cycle.
- SKID_EN=1: states EMPTY(occ 0), FULL(occ 1), SKID(occ 2). in_ready is a flop, equal to (next state != SKID).
  - EMPTY: in_xfer -> FULL, main<=in_data.
  - FULL:
    - in_xfer & out_xfer -> FULL, main<=in_data.
    - in_xfer & !out_xfer -> SKID, skid<=in_data.
    - !in_xfer & out_xfer -> EMPTY.
    - else hold.
  - SKID: out_xfer -> FULL, main<=skid. No input is accepted (in_ready=0).
  - Order strictly FIFO. No entry is lost or duplicated. Latency 1 cycle; sustained throughput 1/cycle.
- Boundary conditions:
  - in_valid while SKID: no transfer; upstream must hold.
  - out_data must stay stable while out_valid & !out_xfer.
  - Stall for N cycles with in_valid high: at most 2 entries (1 if SKID_EN=0) absorbed, then in_ready=0.
  - flush and rst in the same cycle: reset wins, so flush_out=0.
  - Back-to-back flush: flush_out high each following cycle.
- occupancy reflects the registered state. It never reads 3; the bench asserts this.

Decomposition:
- Shared package pipe_pkg:
  - skid state enum (EMPTY/FULL/SKID, 2-bit).
  - per-boundary payload width constants (EX_MEM1_W=44 etc.).
  - field offset constants for packing/unpacking stage bundles.
- No sub-module. The state machine and two data registers are a single flat block. Stage wrappers only pack/unpack payloads.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1, in_data=0xABC -> out_valid=0, out_data=0, occupancy=0, flush_out=0; in_ready=1 on first post-reset cycle.
- Streaming: SKID_EN=1, out_ready=1, send 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each, with no bubbles.
- Stall absorb: FULL holding 0x10, stall=1 for 3 cycles, input offers 0x11,0x12 -> 0x11 enters skid, in_ready=0 next, 0x12 held upstream. Release stall -> out order 0x10,0x11,0x12.
- Flush: SKID state with 0x20/0x21, flush=1 together with in_xfer of 0x22 -> next cycle out_valid=0, occupancy=0, flush_out=1 one cycle; 0x22 never appears.
- SKID_EN=0: out_ready=0 with entry 0x30 -> in_ready=0 same cycle. Raise out_ready -> in_ready=1 combinationally, and 0x31 replaces 0x30 in one cycle.
- Random: random in_valid/out_ready/stall/flush for 10k cycles against a reference queue model -> no loss, reorder or duplication; occupancy ≤ 2.
